// File: rtl/aes_req_arbiter_if.sv
// Signal bundle linking two AES requesters, the controller FIFOs and aes_req_arbiter.
// slave = arbiter side, master = requester/controller environment side.
`ifndef AES_ARB_DEFS
`define AES_ARB_DEFS
`define WORD_S 7:0
`define SET_KEY_128     8'h01
`define ECB_ENCRYPT_128 8'h02
`define ECB_DECRYPT_128 8'h03
`define CBC_ENCRYPT_128 8'h04
`define CBC_DECRYPT_128 8'h05
`endif

interface aes_req_arbiter_if;
  logic [127:0]   s0_tdata;
  logic [127:0]   s1_tdata;
  logic           s0_tvalid;
  logic           s1_tvalid;
  logic           s0_tlast;
  logic           s1_tlast;
  logic           s0_tready;
  logic           s1_tready;
  logic [`WORD_S] s0_cmd;
  logic [`WORD_S] s1_cmd;

  logic [127:0]   m_tdata;
  logic           m_tvalid;
  logic           m_tlast;
  logic           m_tready;
  logic [`WORD_S] aes_cmd;

  logic [127:0]   r_tdata;
  logic           r_tvalid;
  logic           r_tready;

  logic [127:0]   d0_tdata;
  logic [127:0]   d1_tdata;
  logic           d0_tvalid;
  logic           d1_tvalid;
  logic           d0_tready;
  logic           d1_tready;

  logic           processing_done;
  logic [1:0]     grant;

  modport slave (
    input  s0_tdata, s1_tdata, s0_tvalid, s1_tvalid, s0_tlast, s1_tlast, s0_cmd, s1_cmd,
    input  m_tready, r_tdata, r_tvalid, d0_tready, d1_tready, processing_done,
    output s0_tready, s1_tready, m_tdata, m_tvalid, m_tlast, aes_cmd,
    output r_tready, d0_tdata, d1_tdata, d0_tvalid, d1_tvalid, grant
  );

  modport master (
    output s0_tdata, s1_tdata, s0_tvalid, s1_tvalid, s0_tlast, s1_tlast, s0_cmd, s1_cmd,
    output m_tready, r_tdata, r_tvalid, d0_tready, d1_tready, processing_done,
    input  s0_tready, s1_tready, m_tdata, m_tvalid, m_tlast, aes_cmd,
    input  r_tready, d0_tdata, d1_tdata, d0_tvalid, d1_tvalid, grant
  );
endinterface

// File: rtl/aes_req_arbiter.sv
// Two-requester arbiter in front of one AES controller: owns the controller for a whole frame.
// Define AES_ARB_FIXED_PRIO_EN to make requester 0 always win a tie (default is round-robin).
`ifndef AES_ARB_DEFS
`define AES_ARB_DEFS
`define WORD_S 7:0
`define SET_KEY_128     8'h01
`define ECB_ENCRYPT_128 8'h02
`define ECB_DECRYPT_128 8'h03
`define CBC_ENCRYPT_128 8'h04
`define CBC_DECRYPT_128 8'h05
`endif

module aes_req_arbiter #(
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             reset_n,
  aes_req_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, FWD, DRAIN, RELEASE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_reg, state_next;
  logic [1:0]       grant_reg, grant_next;
  logic             last_reg, last_next;
  logic [`WORD_S]   cmd_reg, cmd_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             done_seen_reg, done_seen_next;
  logic [1:0]       beat_reg, beat_next;

  logic         sel;
  logic         fwd;
  logic [127:0] src_tdata;
  logic         src_tvalid;
  logic         src_tlast;
  logic         dst_tready;
  logic         is_cbc;
  logic         is_data;
  logic         in_block;
  logic         in_acc;
  logic         out_en;
  logic         out_acc;
  logic         winner;

  assign sel        = grant_reg[1];
  assign fwd        = (state_reg == FWD);
  assign src_tdata  = sel ? bus.s1_tdata  : bus.s0_tdata;
  assign src_tvalid = sel ? bus.s1_tvalid : bus.s0_tvalid;
  assign src_tlast  = sel ? bus.s1_tlast  : bus.s0_tlast;
  assign dst_tready = sel ? bus.d1_tready : bus.d0_tready;

  // beat_reg saturates at 2: 0 = key, 1 = IV (CBC) or first block, 2 = data from here on
  assign is_cbc   = (cmd_reg == `CBC_ENCRYPT_128) || (cmd_reg == `CBC_DECRYPT_128);
  assign is_data  = (beat_reg == 2'd2) || ((beat_reg == 2'd1) && !is_cbc);
  assign in_block = is_data && (cnt_reg == CNT_MAX);
  assign in_acc   = fwd && src_tvalid && bus.m_tready && !in_block;

  assign out_en  = ((state_reg == FWD) || (state_reg == DRAIN)) && (cnt_reg != '0);
  assign out_acc = out_en && bus.r_tvalid && dst_tready;

`ifdef AES_ARB_FIXED_PRIO_EN
  assign winner = !bus.s0_tvalid;
`else
  assign winner = (bus.s0_tvalid && bus.s1_tvalid) ? ~last_reg : bus.s1_tvalid;
`endif

  // A blocked beat is hidden from the FIFO as well, so it is never written without being accepted.
  assign bus.m_tdata   = fwd ? src_tdata : '0;
  assign bus.m_tvalid  = fwd && src_tvalid && !in_block;
  assign bus.m_tlast   = fwd && src_tlast;
  assign bus.s0_tready = fwd && !sel && bus.m_tready && !in_block;
  assign bus.s1_tready = fwd &&  sel && bus.m_tready && !in_block;
  assign bus.aes_cmd   = cmd_reg;
  assign bus.grant     = grant_reg;

  // Results only flow while something is outstanding; d*_tvalid is gated the same way as r_tready.
  assign bus.r_tready  = out_en && dst_tready;
  assign bus.d0_tdata  = (out_en && !sel) ? bus.r_tdata : '0;
  assign bus.d1_tdata  = (out_en &&  sel) ? bus.r_tdata : '0;
  assign bus.d0_tvalid = out_en && !sel && bus.r_tvalid;
  assign bus.d1_tvalid = out_en &&  sel && bus.r_tvalid;

  always_comb begin
    state_next     = state_reg;
    grant_next     = grant_reg;
    last_next      = last_reg;
    cmd_next       = cmd_reg;
    cnt_next       = cnt_reg;
    done_seen_next = done_seen_reg;
    beat_next      = beat_reg;

    case ({in_acc && is_data, out_acc})
      2'b10:   cnt_next = cnt_reg + CNT_ONE;
      2'b01:   cnt_next = cnt_reg - CNT_ONE;
      default: cnt_next = cnt_reg;
    endcase

    if (in_acc && (beat_reg != 2'd2)) begin
      beat_next = beat_reg + 2'd1;
    end

    if (((state_reg == FWD) || (state_reg == DRAIN)) && bus.processing_done) begin
      done_seen_next = 1'b1;
    end

    case (state_reg)
      IDLE: begin
        if (bus.s0_tvalid || bus.s1_tvalid) begin
          grant_next     = winner ? 2'b10 : 2'b01;
          cmd_next       = winner ? bus.s1_cmd : bus.s0_cmd;
          beat_next      = 2'd0;
          done_seen_next = 1'b0;
          cnt_next       = '0;
          state_next     = FWD;
        end
      end
      FWD: begin
        if (in_acc && src_tlast) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if ((cnt_reg == '0) && (done_seen_reg || bus.processing_done)) begin
          state_next = RELEASE;
        end
      end
      RELEASE: begin
        grant_next = 2'b00;
        last_next  = grant_reg[1];
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      grant_reg     <= 2'b00;
      last_reg      <= 1'b1;
      cmd_reg       <= '0;
      cnt_reg       <= '0;
      done_seen_reg <= 1'b0;
      beat_reg      <= 2'd0;
    end else begin
      state_reg     <= state_next;
      grant_reg     <= grant_next;
      last_reg      <= last_next;
      cmd_reg       <= cmd_next;
      cnt_reg       <= cnt_next;
      done_seen_reg <= done_seen_next;
      beat_reg      <= beat_next;
    end
  end
endmodule

// File: tb/tb_aes_req_arbiter.sv
// Self-checking bench for aes_req_arbiter: the bench plays both requesters and the AES controller.
// Expected streams come from the frames the bench itself generates.
`ifndef AES_ARB_DEFS
`define AES_ARB_DEFS
`define WORD_S 7:0
`define SET_KEY_128     8'h01
`define ECB_ENCRYPT_128 8'h02
`define ECB_DECRYPT_128 8'h03
`define CBC_ENCRYPT_128 8'h04
`define CBC_DECRYPT_128 8'h05
`endif

module tb_aes_req_arbiter;
  localparam int CNT_W   = 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int LIMIT   = 200;
  localparam logic [127:0] MASK = 128'h5a5a_a5a5_0f0f_f0f0_3c3c_c3c3_9696_6969;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  aes_req_arbiter_if bus();

  aes_req_arbiter #(.CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks   = 0;
  int failures = 0;
  bit rnd_en   = 1'b0;

  logic [127:0] exp_m[$];
  logic [127:0] exp_d[$];
  logic [127:0] ret_q[$];
  logic [127:0] got_m[$];
  bit           got_mlast[$];
  logic [127:0] got_d0[$];
  logic [127:0] got_d1[$];
  int peak   = 0;
  int d0_bad = 0;
  int d1_bad = 0;

  always @(negedge clk) begin
    if (bus.m_tvalid && bus.m_tready) begin
      got_m.push_back(bus.m_tdata);
      got_mlast.push_back(bus.m_tlast);
    end
    if (bus.d0_tvalid && bus.d0_tready) got_d0.push_back(bus.d0_tdata);
    if (bus.d1_tvalid && bus.d1_tready) got_d1.push_back(bus.d1_tdata);
    if (int'(dut.cnt_reg) > peak) peak = int'(dut.cnt_reg);
    if (bus.d0_tvalid && bus.grant != 2'b01) d0_bad++;
    if (bus.d1_tvalid && bus.grant != 2'b10) d1_bad++;
  end

  initial begin
    bus.m_tready  = 1'b1;
    bus.d0_tready = 1'b1;
    bus.d1_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rnd_en) begin
        bus.m_tready  = ($urandom_range(0, 3) != 0);
        bus.d0_tready = ($urandom_range(0, 3) != 0);
        bus.d1_tready = ($urandom_range(0, 3) != 0);
      end else begin
        bus.m_tready  = 1'b1;
        bus.d0_tready = 1'b1;
        bus.d1_tready = 1'b1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    reset_n = 1'b0;
    bus.s0_tvalid = 0; bus.s1_tvalid = 0; bus.s0_tlast = 0; bus.s1_tlast = 0;
    bus.s0_tdata = '0; bus.s1_tdata = '0; bus.s0_cmd = '0; bus.s1_cmd = '0;
    bus.r_tvalid = 0; bus.r_tdata = '0; bus.processing_done = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic clear_queues();
    exp_m.delete(); exp_d.delete(); ret_q.delete();
    got_m.delete(); got_mlast.delete(); got_d0.delete(); got_d1.delete();
    peak = 0; d0_bad = 0; d1_bad = 0;
  endtask

  task automatic put_beat(input int req, input logic [127:0] data, input bit last, output bit ok);
    ok = 1'b0;
    if (req == 0) begin bus.s0_tdata = data; bus.s0_tlast = last; bus.s0_tvalid = 1'b1; end
    else          begin bus.s1_tdata = data; bus.s1_tlast = last; bus.s1_tvalid = 1'b1; end
    for (int i = 0; i < LIMIT && !ok; i++) begin
      @(negedge clk);
      if ((req == 0) ? bus.s0_tready : bus.s1_tready) ok = 1'b1;
      @(posedge clk); #1;
    end
    if (req == 0) bus.s0_tvalid = 1'b0; else bus.s1_tvalid = 1'b0;
  endtask

  task automatic send_frame(input int req, input logic [`WORD_S] cmd, input int nbeats,
                            input int n_hdr, output bit ok);
    logic [127:0] data;
    bit b;
    ok = 1'b1;
    if (req == 0) bus.s0_cmd = cmd; else bus.s1_cmd = cmd;
    for (int i = 0; i < nbeats; i++) begin
      data = {$urandom, $urandom, $urandom, $urandom};
      exp_m.push_back(data);
      if (i >= n_hdr) begin
        ret_q.push_back(data ^ MASK);
        exp_d.push_back(data ^ MASK);
      end
      put_beat(req, data, (i == nbeats - 1), b);
      if (!b) ok = 1'b0;
    end
  endtask

  task automatic return_results(input int n, output bit ok);
    bit got;
    ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      got = 1'b0;
      bus.r_tdata  = ret_q.pop_front();
      bus.r_tvalid = 1'b1;
      for (int k = 0; k < LIMIT && !got; k++) begin
        @(negedge clk);
        if (bus.r_tready) got = 1'b1;
        @(posedge clk); #1;
      end
      bus.r_tvalid = 1'b0;
      if (!got) ok = 1'b0;
    end
  endtask

  task automatic pulse_done();
    bus.processing_done = 1'b1;
    @(posedge clk); #1;
    bus.processing_done = 1'b0;
  endtask

  task automatic wait_grant(input logic [1:0] g, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < LIMIT && !ok; i++) begin
      @(negedge clk);
      if (bus.grant == g) ok = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_grant_nz(output logic [1:0] g, output bit ok);
    ok = 1'b0;
    g  = 2'b00;
    for (int i = 0; i < LIMIT && !ok; i++) begin
      @(negedge clk);
      if (bus.grant != 2'b00) begin ok = 1'b1; g = bus.grant; end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    checks++; if (bus.grant !== 2'b00) begin failures++; $display("FAIL reset_grant got=%b exp=00", bus.grant); end
    checks++; if (bus.m_tvalid !== 1'b0) begin failures++; $display("FAIL reset_m_tvalid got=%b exp=0", bus.m_tvalid); end
    checks++; if ({bus.s0_tready, bus.s1_tready, bus.r_tready} !== 3'b000) begin failures++; $display("FAIL reset_treadys got=%b exp=000", {bus.s0_tready, bus.s1_tready, bus.r_tready}); end
    checks++; if ({bus.d0_tvalid, bus.d1_tvalid} !== 2'b00) begin failures++; $display("FAIL reset_d_tvalid got=%b exp=00", {bus.d0_tvalid, bus.d1_tvalid}); end
    checks++; if (bus.aes_cmd !== 8'h00) begin failures++; $display("FAIL reset_aes_cmd got=%h exp=00", bus.aes_cmd); end
    checks++; if (int'(dut.cnt_reg) != 0) begin failures++; $display("FAIL reset_count got=%0d exp=0", dut.cnt_reg); end
    @(posedge clk); #1;
  endtask

  task automatic test_ecb_frame();
    bit ok;
    clear_queues();
    rnd_en = 1'b1;
    send_frame(0, `ECB_ENCRYPT_128, 4, 1, ok);
    checks++; if (!ok) begin failures++; $display("FAIL ecb_send got=timeout exp=accepted"); end
    checks++; if (bus.grant !== 2'b01) begin failures++; $display("FAIL ecb_grant got=%b exp=01", bus.grant); end
    checks++; if (bus.aes_cmd !== `ECB_ENCRYPT_128) begin failures++; $display("FAIL ecb_cmd got=%h exp=%h", bus.aes_cmd, `ECB_ENCRYPT_128); end
    checks++; if (got_m.size() != 4) begin failures++; $display("FAIL ecb_m_count got=%0d exp=4", got_m.size()); end
    for (int i = 0; i < 4 && i < got_m.size(); i++) begin
      checks++; if (got_m[i] !== exp_m[i] || got_mlast[i] != (i == 3)) begin failures++; $display("FAIL ecb_m_beat%0d got=%h/%0d exp=%h/%0d", i, got_m[i], got_mlast[i], exp_m[i], (i == 3)); end
    end
    return_results(3, ok);
    checks++; if (!ok) begin failures++; $display("FAIL ecb_return got=timeout exp=accepted"); end
    checks++; if (got_d0.size() != 3) begin failures++; $display("FAIL ecb_d0_count got=%0d exp=3", got_d0.size()); end
    for (int i = 0; i < 3 && i < got_d0.size(); i++) begin
      checks++; if (got_d0[i] !== exp_d[i]) begin failures++; $display("FAIL ecb_d0_beat%0d got=%h exp=%h", i, got_d0[i], exp_d[i]); end
    end
    pulse_done();
    wait_grant(2'b00, ok);
    checks++; if (!ok) begin failures++; $display("FAIL ecb_release got=%b exp=00", bus.grant); end
    checks++; if (got_d1.size() != 0 || d0_bad != 0) begin failures++; $display("FAIL ecb_stray_d got=%0d/%0d exp=0/0", got_d1.size(), d0_bad); end
    rnd_en = 1'b0;
  endtask

  task automatic test_tie();
    bit ok;
    logic [1:0] g;
    logic [1:0] exp2;
    logic [1:0] exp3;
`ifdef AES_ARB_FIXED_PRIO_EN
    exp2 = 2'b01; exp3 = 2'b10;
`else
    exp2 = 2'b10; exp3 = 2'b01;
`endif
    apply_reset();
    clear_queues();
    bus.s0_cmd = `SET_KEY_128; bus.s1_cmd = `SET_KEY_128;
    bus.s0_tdata = {4{$urandom}}; bus.s1_tdata = {4{$urandom}};
    bus.s0_tlast = 1'b1; bus.s1_tlast = 1'b1;
    bus.s0_tvalid = 1'b1; bus.s1_tvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (bus.grant !== 2'b01) begin failures++; $display("FAIL tie_first got=%b exp=01", bus.grant); end
    put_beat(0, {4{$urandom}}, 1'b1, ok);
    bus.s0_tvalid = 1'b1;
    pulse_done();
    wait_grant(2'b00, ok);
    wait_grant_nz(g, ok);
    checks++; if (!ok || g !== exp2) begin failures++; $display("FAIL tie_second got=%b exp=%b", g, exp2); end
    put_beat(g[1] ? 1 : 0, {4{$urandom}}, 1'b1, ok);
    pulse_done();
    wait_grant(2'b00, ok);
    wait_grant_nz(g, ok);
    checks++; if (!ok || g !== exp3) begin failures++; $display("FAIL tie_third got=%b exp=%b", g, exp3); end
    put_beat(g[1] ? 1 : 0, {4{$urandom}}, 1'b1, ok);
    pulse_done();
    wait_grant(2'b00, ok);
    checks++; if (!ok) begin failures++; $display("FAIL tie_release got=%b exp=00", bus.grant); end
  endtask

  task automatic test_cbc_decrypt();
    bit ok;
    clear_queues();
    rnd_en = 1'b1;
    send_frame(1, `CBC_DECRYPT_128, 4, 2, ok);
    checks++; if (!ok) begin failures++; $display("FAIL cbc_send got=timeout exp=accepted"); end
    checks++; if (bus.grant !== 2'b10) begin failures++; $display("FAIL cbc_grant got=%b exp=10", bus.grant); end
    checks++; if (got_m.size() != 4) begin failures++; $display("FAIL cbc_m_count got=%0d exp=4", got_m.size()); end
    return_results(2, ok);
    checks++; if (!ok) begin failures++; $display("FAIL cbc_return got=timeout exp=accepted"); end
    checks++; if (peak != 2) begin failures++; $display("FAIL cbc_peak got=%0d exp=2", peak); end
    checks++; if (got_d1.size() != 2) begin failures++; $display("FAIL cbc_d1_count got=%0d exp=2", got_d1.size()); end
    for (int i = 0; i < 2 && i < got_d1.size(); i++) begin
      checks++; if (got_d1[i] !== exp_d[i]) begin failures++; $display("FAIL cbc_d1_beat%0d got=%h exp=%h", i, got_d1[i], exp_d[i]); end
    end
    pulse_done();
    wait_grant(2'b00, ok);
    checks++; if (!ok) begin failures++; $display("FAIL cbc_release got=%b exp=00", bus.grant); end
    checks++; if (got_d0.size() != 0 || d0_bad != 0 || d1_bad != 0) begin failures++; $display("FAIL cbc_d0_idle got=%0d/%0d/%0d exp=0/0/0", got_d0.size(), d0_bad, d1_bad); end
    rnd_en = 1'b0;
  endtask

  task automatic test_same_cycle();
    bit ok;
    clear_queues();
    bus.s0_cmd = `ECB_ENCRYPT_128;
    put_beat(0, {4{$urandom}}, 1'b0, ok);
    put_beat(0, {4{$urandom}}, 1'b0, ok);
    checks++; if (int'(dut.cnt_reg) != 1) begin failures++; $display("FAIL same_pre_count got=%0d exp=1", dut.cnt_reg); end
    bus.s0_tdata = {4{$urandom}}; bus.s0_tlast = 1'b0; bus.s0_tvalid = 1'b1;
    bus.r_tdata = {4{$urandom}}; bus.r_tvalid = 1'b1;
    @(negedge clk);
    checks++; if ({bus.s0_tready, bus.r_tready} !== 2'b11) begin failures++; $display("FAIL same_both_ready got=%b exp=11", {bus.s0_tready, bus.r_tready}); end
    @(posedge clk); #1;
    bus.s0_tvalid = 1'b0; bus.r_tvalid = 1'b0;
    checks++; if (int'(dut.cnt_reg) != 1) begin failures++; $display("FAIL same_count got=%0d exp=1", dut.cnt_reg); end
    put_beat(0, {4{$urandom}}, 1'b1, ok);
    ret_q.push_back({4{$urandom}}); ret_q.push_back({4{$urandom}});
    return_results(2, ok);
    pulse_done();
    wait_grant(2'b00, ok);
    checks++; if (!ok || got_d0.size() != 3) begin failures++; $display("FAIL same_d0_count got=%0d exp=3", got_d0.size()); end
  endtask

  task automatic test_set_key();
    bit ok;
    clear_queues();
    bus.s0_cmd = `SET_KEY_128;
    put_beat(0, {4{$urandom}}, 1'b1, ok);
    checks++; if (!ok || bus.grant !== 2'b01) begin failures++; $display("FAIL setkey_drain_grant got=%b exp=01", bus.grant); end
    checks++; if (int'(dut.cnt_reg) != 0) begin failures++; $display("FAIL setkey_count got=%0d exp=0", dut.cnt_reg); end
    bus.r_tdata = {4{$urandom}}; bus.r_tvalid = 1'b1;
    @(negedge clk);
    checks++; if ({bus.r_tready, bus.d0_tvalid} !== 2'b00) begin failures++; $display("FAIL underflow_hold got=%b exp=00", {bus.r_tready, bus.d0_tvalid}); end
    @(posedge clk); #1;
    bus.r_tvalid = 1'b0;
    pulse_done();
    wait_grant(2'b00, ok);
    checks++; if (!ok) begin failures++; $display("FAIL setkey_release got=%b exp=00", bus.grant); end
    checks++; if (got_d0.size() != 0 || got_m.size() != 1) begin failures++; $display("FAIL setkey_beats got=d0:%0d m:%0d exp=d0:0 m:1", got_d0.size(), got_m.size()); end
  endtask

  task automatic test_overflow();
    bit ok;
    clear_queues();
    bus.s0_cmd = `ECB_ENCRYPT_128;
    for (int i = 0; i < CNT_MAX + 1; i++) begin
      put_beat(0, {4{$urandom}}, 1'b0, ok);
      ret_q.push_back({4{$urandom}});
    end
    ret_q.push_back({4{$urandom}});
    checks++; if (int'(dut.cnt_reg) != CNT_MAX) begin failures++; $display("FAIL ovf_full got=%0d exp=%0d", dut.cnt_reg, CNT_MAX); end
    bus.s0_tdata = {4{$urandom}}; bus.s0_tlast = 1'b1; bus.s0_tvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if ({bus.s0_tready, bus.m_tvalid} !== 2'b00) begin failures++; $display("FAIL ovf_block%0d got=%b exp=00", i, {bus.s0_tready, bus.m_tvalid}); end
    end
    @(posedge clk); #1;
    return_results(1, ok);
    put_beat(0, bus.s0_tdata, 1'b1, ok);
    checks++; if (!ok) begin failures++; $display("FAIL ovf_resume got=timeout exp=accepted"); end
    return_results(CNT_MAX, ok);
    pulse_done();
    wait_grant(2'b00, ok);
    checks++; if (!ok || got_m.size() != CNT_MAX + 2) begin failures++; $display("FAIL ovf_frame got=%0d exp=%0d", got_m.size(), CNT_MAX + 2); end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    int n_m;
    clear_queues();
    bus.s0_cmd = `ECB_ENCRYPT_128;
    put_beat(0, {4{$urandom}}, 1'b0, ok);
    put_beat(0, {4{$urandom}}, 1'b0, ok);
    bus.s0_tdata = {4{$urandom}}; bus.s0_tlast = 1'b0; bus.s0_tvalid = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if ({bus.m_tvalid, bus.s0_tready, bus.r_tready, bus.d0_tvalid} !== 4'b0000) begin failures++; $display("FAIL midrst_outputs got=%b exp=0000", {bus.m_tvalid, bus.s0_tready, bus.r_tready, bus.d0_tvalid}); end
    checks++; if (bus.grant !== 2'b00 || bus.aes_cmd !== 8'h00) begin failures++; $display("FAIL midrst_grant got=%b/%h exp=00/00", bus.grant, bus.aes_cmd); end
    n_m = got_m.size();
    bus.s0_tvalid = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (got_m.size() != n_m || n_m != 2) begin failures++; $display("FAIL midrst_no_beats got=%0d exp=2", got_m.size()); end
    bus.s1_cmd = `SET_KEY_128;
    put_beat(1, {4{$urandom}}, 1'b1, ok);
    checks++; if (!ok || bus.grant !== 2'b10) begin failures++; $display("FAIL midrst_s1_grant got=%b exp=10", bus.grant); end
    pulse_done();
    wait_grant(2'b00, ok);
    checks++; if (!ok || got_m.size() != 3) begin failures++; $display("FAIL midrst_s1_frame got=%0d exp=3", got_m.size()); end
  endtask

  initial begin
    test_reset();
    test_ecb_frame();
    test_tie();
    test_cbc_decrypt();
    test_same_cycle();
    test_set_key();
    test_overflow();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
